// File: rtl/core_mem_arbiter_pkg.sv
// Shared encodings and FSM states for the multi-port memory responder.
`ifndef CMA_SLICE
`define CMA_SLICE(i, w) (i)*(w) +: (w)
`endif

package core_mem_arbiter_pkg;
  localparam logic [1:0] EN_IDLE = 2'b00;
  localparam logic [1:0] EN_RD   = 2'b01;
  localparam logic [1:0] EN_WR   = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

  // 2'b11 is accepted as a write
  function automatic logic is_write(input logic [1:0] en);
    return (en == EN_WR) || (en == (EN_WR | EN_RD));
  endfunction
endpackage

// File: rtl/core_mem_arbiter_rr_arbiter.sv
// Round-robin pick over N_PORTS requesters; search starts one past the last grant.
module rr_arbiter #(
  parameter int N_PORTS = 4,
  parameter int IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_PORTS-1:0] req,
  input  logic               take,
  output logic               found,
  output logic [IDX_W-1:0]   pick
);
  localparam int REQ_W = 1 << IDX_W;

  logic [IDX_W-1:0] last_grant;
  logic [REQ_W-1:0] req_p;

  // pad so any IDX_W-bit index is in range
  assign req_p = REQ_W'(req);

  always_comb begin
    int c;
    logic [IDX_W-1:0] ci;
    c     = 0;
    ci    = '0;
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      c = int'(last_grant) + k;
      if (c >= N_PORTS) c = c - N_PORTS;
      ci = IDX_W'(c);
      if (!found && req_p[ci]) begin
        found = 1'b1;
        pick  = ci;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) last_grant <= IDX_W'(N_PORTS - 1);
    else if (take && found) last_grant <= pick;
  end
endmodule

// File: rtl/core_mem_arbiter.sv
// Shared on-chip RAM serving N_PORTS core memory ports, one transaction at a time.
`ifndef CMA_SLICE
`define CMA_SLICE(i, w) (i)*(w) +: (w)
`endif

module core_mem_arbiter
  import core_mem_arbiter_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2*N_PORTS-1:0]        enable_bus,
  input  logic [ADDR_W*N_PORTS-1:0]   addr_bus,
  input  logic [DATA_W*N_PORTS-1:0]   wr_data_bus,
  output logic [N_PORTS-1:0]          ready_bus,
  output logic [DATA_W*N_PORTS-1:0]   rd_data_bus,
  output logic                        busy
);
  localparam int IDX_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CNT_W  = $clog2(LATENCY + 1);
  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(LATENCY - 1);
  localparam logic [N_PORTS-1:0] PORT0    = N_PORTS'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  gidx;
  logic              gwr;
  logic [ADDR_W-1:0] gaddr;
  logic [DATA_W-1:0] gdata;

  logic [N_PORTS-1:0] req;
  logic               found;
  logic [IDX_W-1:0]   pick;
  logic [1:0]         sel_en;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               in_range;
  logic               last_cyc;
  logic               commit;
  logic [RAM_AW-1:0]  ram_idx;

  for (genvar i = 0; i < N_PORTS; i++) begin : g_req
    assign req[i] = enable_bus[`CMA_SLICE(i, 2)] != EN_IDLE;
  end

  rr_arbiter #(.N_PORTS(N_PORTS), .IDX_W(IDX_W)) u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .take  (state == ST_IDLE),
    .found (found),
    .pick  (pick)
  );

  assign sel_en   = enable_bus[`CMA_SLICE(pick, 2)];
  assign sel_addr = addr_bus[`CMA_SLICE(pick, ADDR_W)];
  assign sel_data = wr_data_bus[`CMA_SLICE(pick, DATA_W)];

  assign in_range = {1'b0, gaddr} < (ADDR_W + 1)'(DEPTH);
  assign ram_idx  = gaddr[RAM_AW-1:0];
  assign last_cyc = (cnt == CNT_LAST);
  // reset gating drops a write whose commit cycle coincides with reset
  assign commit   = reset && (state == ST_ACCESS) && last_cyc && gwr && in_range;

  always_ff @(posedge clk) begin
    if (commit) mem[ram_idx] <= gdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      gidx        <= '0;
      gwr         <= 1'b0;
      gaddr       <= '0;
      gdata       <= '0;
      ready_bus   <= '0;
      rd_data_bus <= '0;
      busy        <= 1'b0;
    end else begin
      ready_bus <= '0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            gidx  <= pick;
            gwr   <= is_write(sel_en);
            gaddr <= sel_addr;
            gdata <= sel_data;
            cnt   <= '0;
            state <= ST_ACCESS;
            busy  <= 1'b1;
          end
        end
        ST_ACCESS: begin
          if (last_cyc) begin
            if (!gwr)
              rd_data_bus[`CMA_SLICE(gidx, DATA_W)] <= in_range ? mem[ram_idx] : '0;
            ready_bus <= PORT0 << gidx;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench: 4-port LATENCY=1, 1-port LATENCY=3, and 1-port DEPTH=128 instances.
module tb_core_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic [7:0]  en    = '0;
  logic [31:0] addr  = '0;
  logic [31:0] wd    = '0;
  logic [3:0]  rdy;
  logic [31:0] rdd;
  logic        busy;

  logic [1:0] en1 = '0, en2 = '0;
  logic [7:0] a1 = '0, w1 = '0, a2 = '0, w2 = '0;
  logic       rdy1, rdy2, busy1, busy2;
  logic [7:0] r1, r2;

  int checks = 0;
  int failures = 0;

  core_mem_arbiter #(.N_PORTS(4), .DATA_W(8), .ADDR_W(8), .DEPTH(256), .LATENCY(1)) u0 (
    .clk(clk), .reset(reset), .enable_bus(en), .addr_bus(addr), .wr_data_bus(wd),
    .ready_bus(rdy), .rd_data_bus(rdd), .busy(busy));

  core_mem_arbiter #(.N_PORTS(1), .DATA_W(8), .ADDR_W(8), .DEPTH(256), .LATENCY(3)) u1 (
    .clk(clk), .reset(reset), .enable_bus(en1), .addr_bus(a1), .wr_data_bus(w1),
    .ready_bus(rdy1), .rd_data_bus(r1), .busy(busy1));

  core_mem_arbiter #(.N_PORTS(1), .DATA_W(8), .ADDR_W(8), .DEPTH(128), .LATENCY(1)) u2 (
    .clk(clk), .reset(reset), .enable_bus(en2), .addr_bus(a2), .wr_data_bus(w2),
    .ready_bus(rdy2), .rd_data_bus(r2), .busy(busy2));

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; en = '0; en1 = '0; en2 = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // one transaction on a u0 port; returns ready cycle (0 = timed out)
  task automatic u0_txn(input int p, input logic [1:0] code, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output int cyc, output int bsy, output int stray);
    logic [3:0] mine;
    @(posedge clk); #1;
    en[p*2 +: 2] = code; addr[p*8 +: 8] = a; wd[p*8 +: 8] = d;
    mine = 4'b0001 << p;
    cyc = 0; bsy = 0; stray = 0; rd = '0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (busy) bsy++;
      if ((rdy & ~mine) != 4'b0) stray++;
      if (rdy[p]) begin
        cyc = n; rd = rdd[p*8 +: 8];
        break;
      end
    end
    en[p*2 +: 2] = 2'b00;
  endtask

  // one transaction on u1 (which=1) or u2 (which=2); addr may be changed at cycle chg_at
  task automatic s_txn(input int which, input logic [1:0] code, input logic [7:0] a, input logic [7:0] d,
                       input int chg_at, input logic [7:0] chg_a,
                       output logic [7:0] rd, output int cyc, output int bsy);
    @(posedge clk); #1;
    if (which == 1) begin en1 = code; a1 = a; w1 = d; end
    else begin en2 = code; a2 = a; w2 = d; end
    cyc = 0; bsy = 0; rd = '0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == chg_at) begin
        if (which == 1) a1 = chg_a; else a2 = chg_a;
      end
      if ((which == 1) ? busy1 : busy2) bsy++;
      if ((which == 1) ? rdy1 : rdy2) begin
        cyc = n; rd = (which == 1) ? r1 : r2;
        break;
      end
    end
    en1 = '0; en2 = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rdy !== 4'b0) begin failures++; $display("FAIL reset_ready got=%h want=0", rdy); end
    checks++; if (rdd !== 32'b0) begin failures++; $display("FAIL reset_rd_data got=%h want=0", rdd); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if ({rdy1, rdy2, busy1, busy2, r1, r2} !== 20'b0)
      begin failures++; $display("FAIL reset_small got=%h want=0", {rdy1, rdy2, busy1, busy2, r1, r2}); end
  endtask

  task automatic test_write_read();
    logic [7:0] rd; int cyc, bsy, stray;
    u0_txn(0, 2'b10, 8'd3, 8'h5A, rd, cyc, bsy, stray);
    checks++; if (cyc !== 2) begin failures++; $display("FAIL wr_ready_cycle got=%0d want=2", cyc); end
    checks++; if (bsy !== 2) begin failures++; $display("FAIL wr_busy_cycles got=%0d want=2", bsy); end
    checks++; if (stray !== 0) begin failures++; $display("FAIL wr_stray_ready got=%0d want=0", stray); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_after got=%b want=0", busy); end
    u0_txn(0, 2'b01, 8'd3, 8'h00, rd, cyc, bsy, stray);
    checks++; if (cyc !== 2) begin failures++; $display("FAIL rd_ready_cycle got=%0d want=2", cyc); end
    checks++; if (rd !== 8'h5A) begin failures++; $display("FAIL rd_data got=%h want=5a", rd); end
    checks++; if (bsy !== 2) begin failures++; $display("FAIL rd_busy_cycles got=%0d want=2", bsy); end
  endtask

  task automatic test_round_robin();
    logic [7:0] rd; int cyc, bsy, stray;
    int seen [4];
    int ord [4];
    int when [4];
    logic [7:0] dat [4];
    int nord;
    for (int i = 0; i < 4; i++) begin
      u0_txn(i, 2'b11, 8'(16 + i), 8'(8'hA0 + i), rd, cyc, bsy, stray);
      checks++; if (cyc !== 2) begin failures++; $display("FAIL preload_ready port=%0d got=%0d want=2", i, cyc); end
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      en[i*2 +: 2] = 2'b01; addr[i*8 +: 8] = 8'(16 + i);
      seen[i] = 0; ord[i] = -1; when[i] = 0; dat[i] = '0;
    end
    nord = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 4; p++) begin
        if (rdy[p]) begin
          seen[p]++;
          if (nord < 4) begin ord[nord] = p; when[nord] = n; dat[nord] = rdd[p*8 +: 8]; end
          nord++;
          en[p*2 +: 2] = 2'b00;
        end
      end
    end
    checks++; if (nord !== 4) begin failures++; $display("FAIL rr_total_ready got=%0d want=4", nord); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (ord[k] !== k) begin failures++; $display("FAIL rr_order slot=%0d got=%0d want=%0d", k, ord[k], k); end
      checks++; if (when[k] !== 2 + 3*k) begin failures++; $display("FAIL rr_cycle slot=%0d got=%0d want=%0d", k, when[k], 2 + 3*k); end
      checks++; if (dat[k] !== 8'(8'hA0 + k)) begin failures++; $display("FAIL rr_data slot=%0d got=%h want=%h", k, dat[k], 8'(8'hA0 + k)); end
      checks++; if (seen[k] !== 1) begin failures++; $display("FAIL rr_serve_count port=%0d got=%0d want=1", k, seen[k]); end
    end
    checks++; if (rdd[7:0] !== 8'hA0) begin failures++; $display("FAIL rr_hold_slice0 got=%h want=a0", rdd[7:0]); end
  endtask

  task automatic test_hold_extra();
    int t1, t2, c1, c2;
    logic [7:0] d1;
    t1 = 0; t2 = 0; c1 = 0; c2 = 0; d1 = '0;
    @(posedge clk); #1;
    en[5:4] = 2'b01; addr[23:16] = 8'd18;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (rdy[2]) begin c2++; if (t2 == 0) t2 = n; end
      if (rdy[1]) begin c1++; if (t1 == 0) begin t1 = n; d1 = rdd[15:8]; end en[3:2] = 2'b00; end
      if (t2 != 0 && n == t2) begin en[3:2] = 2'b01; addr[15:8] = 8'd17; end
      if (t2 != 0 && n == t2 + 2) en[5:4] = 2'b00;
    end
    en = '0;
    checks++; if (t2 !== 2) begin failures++; $display("FAIL hold_p2_cycle got=%0d want=2", t2); end
    checks++; if (t1 !== 5) begin failures++; $display("FAIL hold_p1_cycle got=%0d want=5", t1); end
    checks++; if (c2 !== 1) begin failures++; $display("FAIL hold_p2_count got=%0d want=1", c2); end
    checks++; if (c1 !== 1) begin failures++; $display("FAIL hold_p1_count got=%0d want=1", c1); end
    checks++; if (d1 !== 8'hA1) begin failures++; $display("FAIL hold_p1_data got=%h want=a1", d1); end
  endtask

  task automatic test_latency3();
    logic [7:0] rd; int cyc, bsy;
    s_txn(1, 2'b10, 8'd9, 8'h99, 0, 8'd0, rd, cyc, bsy);
    s_txn(1, 2'b10, 8'd7, 8'h11, 0, 8'd0, rd, cyc, bsy);
    checks++; if (cyc !== 4) begin failures++; $display("FAIL lat3_wr_cycle got=%0d want=4", cyc); end
    s_txn(1, 2'b01, 8'd7, 8'h00, 1, 8'd9, rd, cyc, bsy);
    checks++; if (cyc !== 4) begin failures++; $display("FAIL lat3_rd_cycle got=%0d want=4", cyc); end
    checks++; if (rd !== 8'h11) begin failures++; $display("FAIL lat3_rd_data got=%h want=11", rd); end
    checks++; if (bsy !== 4) begin failures++; $display("FAIL lat3_busy_cycles got=%0d want=4", bsy); end
  endtask

  task automatic test_out_of_range();
    logic [7:0] rd; int cyc, bsy;
    s_txn(2, 2'b10, 8'd72, 8'h33, 0, 8'd0, rd, cyc, bsy);
    s_txn(2, 2'b01, 8'd72, 8'h00, 0, 8'd0, rd, cyc, bsy);
    checks++; if (rd !== 8'h33) begin failures++; $display("FAIL oob_pre_rd got=%h want=33", rd); end
    s_txn(2, 2'b10, 8'd200, 8'hFF, 0, 8'd0, rd, cyc, bsy);
    checks++; if (cyc !== 2) begin failures++; $display("FAIL oob_wr_ready got=%0d want=2", cyc); end
    s_txn(2, 2'b01, 8'd200, 8'h00, 0, 8'd0, rd, cyc, bsy);
    checks++; if (cyc !== 2) begin failures++; $display("FAIL oob_rd_ready got=%0d want=2", cyc); end
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL oob_rd_data got=%h want=00", rd); end
    s_txn(2, 2'b01, 8'd72, 8'h00, 0, 8'd0, rd, cyc, bsy);
    checks++; if (rd !== 8'h33) begin failures++; $display("FAIL oob_alias_intact got=%h want=33", rd); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd; int cyc, bsy, stray, extra;
    u0_txn(0, 2'b10, 8'd5, 8'h42, rd, cyc, bsy, stray);
    @(posedge clk); #1;
    en[1:0] = 2'b10; addr[7:0] = 8'd5; wd[7:0] = 8'h77;
    @(posedge clk); #1;
    reset = 1'b0; en[1:0] = 2'b00;
    @(posedge clk); #1;
    checks++; if (rdy !== 4'b0) begin failures++; $display("FAIL mid_ready got=%h want=0", rdy); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b want=0", busy); end
    checks++; if (rdd !== 32'b0) begin failures++; $display("FAIL mid_rd_data got=%h want=0", rdd); end
    reset = 1'b1;
    extra = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      if (rdy != 4'b0) extra++;
    end
    checks++; if (extra !== 0) begin failures++; $display("FAIL mid_late_ready got=%0d want=0", extra); end
    u0_txn(0, 2'b01, 8'd5, 8'h00, rd, cyc, bsy, stray);
    checks++; if (rd !== 8'h42) begin failures++; $display("FAIL mid_old_value got=%h want=42", rd); end
    checks++; if (cyc !== 2) begin failures++; $display("FAIL mid_rd_cycle got=%0d want=2", cyc); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_hold_extra();
    test_latency3();
    test_out_of_range();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Parametrised, synthesizable shared-memory responder for a multi-core build. It serves the per-core memory port (enable/addr/wr_data → ready/rd_data) of `N_PORTS` cores from one on-chip RAM, with round-robin arbitration and a configurable access latency. It sits between the core array and the memory, and replaces the single-core, fixed-delay behavioural memory model.

## Interface
Parameters:
- `N_PORTS`, 4: number of core memory ports, ≥1.
- `DATA_W`, 8: data width; matches the core register width.
- `ADDR_W`, 8: address width per port.
- `DEPTH`, 256: RAM words; must be ≤ 2^`ADDR_W`.
- `LATENCY`, 1: number of ACCESS cycles per transaction, ≥1.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-low.
- `enable_bus`  in  2·N_PORTS  per port `[1:0]`: 2'b01 read, 2'b10 write, 2'b11 treated as write, 2'b00 idle.
- `addr_bus`  in  ADDR_W·N_PORTS  per-port address.
- `wr_data_bus`  in  DATA_W·N_PORTS  per-port write data.
- `ready_bus`  out  N_PORTS  one-cycle completion pulse per port.
- `rd_data_bus`  out  DATA_W·N_PORTS  per-port read data; valid with `ready`.
- `busy`  out  1  high while not in IDLE.

## Operation
- FSM states:
  - IDLE: if any `enable` ≠ 0, grant one port by round-robin, latch that port's index, op, addr and data, then go to ACCESS.
  - ACCESS: the counter runs `LATENCY` cycles. On the last cycle, the write commits or the read data is captured into the granted port's `rd_data` slice; go to DONE.
  - DONE: the granted port's `ready` = 1 for this cycle only; go to IDLE.
- Round-robin:
  - Search starts at `last_grant+1` mod `N_PORTS`.
  - `last_grant` resets to `N_PORTS-1`, so port 0 wins first.
- Requests are level-sensitive. A requester holds `enable`/`addr`/`wr_data` until its `ready` and drops `enable` in the cycle after `ready`.
  - DONE never grants, so a request still asserted during that cycle is not served twice.
- Inputs are sampled only at grant. Changes to the granted port's inputs during ACCESS/DONE are ignored.
- A request withdrawn before grant is dropped silently.
- Out-of-range address (≥ `DEPTH`): a read returns 0, a write is discarded, and `ready` is still issued.
- `rd_data` slices of non-served ports hold their last value.
- RAM contents are not reset.

## Timing
- Reset values: `ready_bus` = 0, `rd_data_bus` = 0, `busy` = 0, state IDLE, counter 0, `last_grant` = N_PORTS-1.
- Request first visible in cycle 0 with the FSM in IDLE:
  - ACCESS occupies cycles 1..LATENCY.
  - `ready` is high in cycle LATENCY+1.
- Earliest next grant is in cycle LATENCY+2; peak throughput is one access per LATENCY+2 cycles.
- Write followed by a read of the same address (any port) returns the new data.
- Simultaneous requests are served one at a time in round-robin order. Each waiting port sees `ready` in its own turn only.
- Reset asserted mid-transaction:
  - abort and return to IDLE the next cycle;
  - no `ready` is issued;
  - a write not yet committed is lost.
- `busy` = (state ≠ IDLE), registered.

## Structure
- Shared package/defines file:
  - enable encodings `EN_IDLE`/`EN_RD`/`EN_WR`;
  - FSM state constants;
  - a bus-slice helper macro for `i*W +: W`.
- One natural sub-module, `rr_arbiter`: a combinational round-robin pick plus the registered `last_grant`, parametrised by `N_PORTS`.
- The RAM is an inferred array in the top; the counter width is `$clog2(LATENCY+1)`.

## Test plan
- N_PORTS=4, LATENCY=1: port 0 writes 0x5A to addr 3, then reads addr 3 → `ready_bus[0]` pulses in cycle 2 of each transaction, read returns 0x5A, `busy` = 1 for 2 cycles each.
- Ports 0..3 request reads together, each holding until its own `ready` → ready order is 0,1,2,3, pulses 3 cycles apart, no double-serve of any port.
- Port 2 holds `enable` one extra cycle after `ready` while port 1 requests → port 1 is granted next and port 2 is not re-served.
- LATENCY=3: read of addr 7 preloaded with 0x11 → `ready` in cycle 4 with `rd_data` = 0x11; modifying `addr` during ACCESS has no effect.
- DEPTH=128, ADDR_W=8: write 0xFF to addr 200, then read addr 200 → both get `ready`, read returns 0, and addr 72 is unchanged.
- Write to addr 5 in progress; reset low in cycle 1 for one cycle → no `ready`, IDLE next cycle, all outputs 0, a later read of addr 5 returns the old value.
